// File: rtl/gf12_sram_pkg.sv
// Shared constants and types for the GF12 8192x64 single-port SRAM leaf bank.
package gf12_sram_pkg;

  localparam int unsigned GF12_SRAM_WORDS = 8192;
  localparam int unsigned GF12_SRAM_WIDTH = 64;
  localparam int unsigned GF12_SRAM_ABITS = 13;

  typedef logic [GF12_SRAM_ABITS-1:0] gf12_sram_addr_t;
  typedef logic [GF12_SRAM_WIDTH-1:0] gf12_sram_data_t;

endpackage

// File: rtl/gf12_sram_bitmask_merge.sv
// Per-bit write-mask merge: bits with mask set take new data, others keep old data.
module gf12_sram_bitmask_merge #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] old_i,
  input  logic [Width-1:0] new_i,
  input  logic [Width-1:0] mask_i,
  output logic [Width-1:0] merged_o
);

  always_comb begin
    merged_o = (old_i & ~mask_i) | (new_i & mask_i);
  end

endmodule

// File: rtl/gf12_sram_sp_8192x64_hd.sv
// Behavioural single-port synchronous SRAM, 8192x64, per-bit write mask,
// one-cycle read latency with Q0 held until the next read.
module gf12_sram_sp_8192x64_hd
  import gf12_sram_pkg::*;
#(
  parameter int unsigned WORDS = GF12_SRAM_WORDS,
  parameter int unsigned WIDTH = GF12_SRAM_WIDTH,
  parameter int unsigned ABITS = GF12_SRAM_ABITS
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE0,
  input  logic [ABITS-1:0] A0,
  input  logic [WIDTH-1:0] D0,
  input  logic             WE0,
  input  logic [WIDTH-1:0] WEM0,
  output logic [WIDTH-1:0] Q0
);

  logic [WIDTH-1:0] mem [WORDS];
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] q_q;
  logic             wr_en;
  logic             rd_en;

  // Writes are blocked during reset; reads are squashed by the async clear.
  always_comb begin
    wr_en = CE0 & WE0 & RSTN;
    rd_en = CE0 & ~WE0;
  end

  assign rd_word = mem[A0];

  gf12_sram_bitmask_merge #(
    .Width (WIDTH)
  ) u_merge (
    .old_i    (rd_word),
    .new_i    (D0),
    .mask_i   (WEM0),
    .merged_o (wr_word)
  );

  // Array has no reset: contents survive RSTN and start uninitialised.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[A0] <= wr_word;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_q <= '0;
    end else if (rd_en) begin
      q_q <= rd_word;
    end
  end

  assign Q0 = q_q;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RSTN) begin
      assert (!$isunknown({CE0, WE0}))
        else $error("gf12_sram: X on CE0/WE0");
      assert (!(CE0 === 1'b1 && $isunknown(A0)))
        else $error("gf12_sram: X on A0 while CE0=1");
    end
  end
`endif

endmodule

// File: tb/tb_gf12_sram_sp_8192x64_hd.sv
// Directed plus randomized bench for gf12_sram_sp_8192x64_hd against a behavioural model.
module tb_gf12_sram_sp_8192x64_hd;
  import gf12_sram_pkg::*;

  logic            CLK;
  logic            RSTN;
  logic            CE0;
  gf12_sram_addr_t A0;
  gf12_sram_data_t D0;
  logic            WE0;
  gf12_sram_data_t WEM0;
  gf12_sram_data_t Q0;

  gf12_sram_sp_8192x64_hd dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .CE0  (CE0),
    .A0   (A0),
    .D0   (D0),
    .WE0  (WE0),
    .WEM0 (WEM0),
    .Q0   (Q0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: sparse memory plus expected output register.
  gf12_sram_data_t ref_mem [int unsigned];
  gf12_sram_data_t q_exp;
  int unsigned     addrs [$];

  localparam gf12_sram_data_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string tag, input gf12_sram_data_t exp);
    checks++;
    assert (Q0 === exp)
      else begin
        errors++;
        $error("FAIL %s: Q0=%h expected %h", tag, Q0, exp);
      end
  endtask

  // One clock cycle: drive at negedge, sample 1ns after the rising edge.
  task automatic op(input string tag, input logic ce, input logic we,
                    input gf12_sram_addr_t a, input gf12_sram_data_t d,
                    input gf12_sram_data_t m);
    gf12_sram_data_t cur;
    @(negedge CLK);
    CE0 = ce; WE0 = we; A0 = a; D0 = d; WEM0 = m;
    @(posedge CLK);
    #1;
    if (!RSTN) begin
      q_exp = '0;
    end else if (ce && we) begin
      cur = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
      for (int b = 0; b < 64; b++) if (m[b]) cur[b] = d[b];
      ref_mem[int'(a)] = cur;
    end else if (ce && !we) begin
      q_exp = ref_mem[int'(a)];
    end
    check(tag, q_exp);
  endtask

  task automatic wr(input string tag, input gf12_sram_addr_t a,
                    input gf12_sram_data_t d, input gf12_sram_data_t m);
    op(tag, 1'b1, 1'b1, a, d, m);
  endtask

  task automatic rd(input string tag, input gf12_sram_addr_t a);
    op(tag, 1'b1, 1'b0, a, '0, '0);
  endtask

  task automatic idle(input string tag);
    op(tag, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gf12_sram_addr_t a;
    gf12_sram_data_t d, m;
    logic ce, we;

    RSTN = 1'b0; CE0 = 1'b0; WE0 = 1'b0; A0 = '0; D0 = '0; WEM0 = '0;
    q_exp = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_init", 64'h0);
    RSTN = 1'b1;

    // Load a known pattern into Q0, then clear it asynchronously.
    wr("pre_wr", 13'h0AAA, 64'hDEADBEEF_CAFEF00D, ONES);
    rd("pre_rd", 13'h0AAA);
    check("pre_val", 64'hDEADBEEF_CAFEF00D);
    RSTN = 1'b0;
    #1;
    q_exp = '0;
    check("async_clear", 64'h0);
    wr("rst_wr_blocked", 13'h0AAA, 64'h0, ONES);
    rd("rst_rd_blocked", 13'h0AAA);
    RSTN = 1'b1;
    idle("rst_release_idle");
    check("rst_release_q0", 64'h0);
    rd("rst_wr_not_applied", 13'h0AAA);
    check("rst_wr_val", 64'hDEADBEEF_CAFEF00D);

    // Full write/read at the top address.
    wr("full_wr", 13'h1FFF, 64'h0123456789ABCDEF, ONES);
    rd("full_rd", 13'h1FFF);
    check("full_val", 64'h0123456789ABCDEF);

    // Masked write, then a no-op write with an empty mask.
    wr("mask_wr1", 13'd5, ONES, ONES);
    wr("mask_wr2", 13'd5, 64'h0, 64'h00000000_FFFFFFFF);
    wr("mask_noop", 13'd5, 64'h0, 64'h0);
    rd("mask_rd", 13'd5);
    check("mask_val", 64'hFFFFFFFF_00000000);

    // Hold through idle cycles and a write.
    for (int i = 0; i < 10; i++) idle("hold_idle");
    wr("hold_wr", 13'd6, 64'h6666_6666_6666_6666, ONES);
    check("hold_val", 64'hFFFFFFFF_00000000);

    // Address independence on bit 12, back-to-back reads.
    wr("ind_wr0", 13'h0000, 64'h1, ONES);
    wr("ind_wr1", 13'h1000, 64'h2, ONES);
    rd("b2b_rd0", 13'h0000);
    check("b2b_val0", 64'h1);
    rd("b2b_rd1", 13'h1000);
    check("b2b_val1", 64'h2);

    // Read sampled in the cycle reset asserts is discarded.
    @(negedge CLK);
    CE0 = 1'b1; WE0 = 1'b0; A0 = 13'h1FFF;
    RSTN = 1'b0;
    @(posedge CLK);
    #1;
    q_exp = '0;
    check("mid_rst_read", 64'h0);
    RSTN = 1'b1;
    idle("mid_rst_idle");

    addrs.push_back(32'h0AAA); addrs.push_back(32'h1FFF); addrs.push_back(32'd5);
    addrs.push_back(32'd6);    addrs.push_back(32'h0);    addrs.push_back(32'h1000);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(4) == 0) begin
        a = gf12_sram_addr_t'($urandom);
        if (!ref_mem.exists(int'(a))) addrs.push_back(int'(a));
        wr("rand_new", a, {$urandom, $urandom}, ONES);
      end else begin
        a  = gf12_sram_addr_t'(addrs[$urandom_range(addrs.size() - 1)]);
        ce = ($urandom_range(3) != 0);
        we = $urandom_range(1) == 1;
        d  = {$urandom, $urandom};
        m  = {$urandom, $urandom};
        op("rand_op", ce, we, a, d, m);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
